hazard_forward_unit: RTL and testbench

// - Pipeline hazard controller feeding the front end of the PA_RISC core: produces PC/IF_ID load enables,
//   the control-unit NOP select (S) and the IF_ID flush, plus operand-forwarding selects for the EX stage.
// - Handles load-use stalls, taken-branch wrong-path squash and PA-RISC nullification of the next instruction.
// - Owns a small FSM and a saturating bubble counter.

---
 rtl/hazard_forward_unit_pkg.sv | 18 +
 rtl/hazard_forward_unit_fwd_select.sv | 34 +++
 rtl/hazard_forward_unit.sv | 142 ++++++++++++++
 tb/tb_hazard_forward_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the hazard / forwarding controller.
package hazard_forward_unit_pkg;

    // Operand source selects driven to the EX-stage operand muxes
    localparam logic [1:0] FW_RF  = 2'b00;
    localparam logic [1:0] FW_EX  = 2'b01;
    localparam logic [1:0] FW_MEM = 2'b10;
    localparam logic [1:0] FW_WB  = 2'b11;

    // Controller states
    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_LU_STALL = 2'b01;
    localparam logic [1:0] ST_FLUSH    = 2'b10;

    // Architectural zero register: never written, so never forwarded
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-operand forwarding comparator: youngest matching producer wins.
module hazard_forward_unit_fwd_select
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_rf_le,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_rf_le,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_rf_le,
    output logic [1:0]       sel
);

    // Priority compare EX > MEM > WB; unused operands and r0 read the RF
    always_comb begin
        sel = FW_RF;
        if (!use_src || (src == REG_W'(REG_ZERO))) begin
            sel = FW_RF;
        end else if (ex_rf_le && (ex_rd == src)) begin
            sel = FW_EX;
        end else if (mem_rf_le && (mem_rd == src)) begin
            sel = FW_MEM;
        end else if (wb_rf_le && (wb_rd == src)) begin
            sel = FW_WB;
        end else begin
            sel = FW_RF;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Front-end hazard controller: load-use stall, taken-branch squash,
// nullification, operand forwarding selects and a saturating bubble counter.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             LE,
    input  logic [REG_W-1:0] ID_RA,
    input  logic [REG_W-1:0] ID_RB,
    input  logic             ID_USE_A,
    input  logic             ID_USE_B,
    input  logic [REG_W-1:0] EX_RD,
    input  logic             EX_RF_LE,
    input  logic             EX_L,
    input  logic [REG_W-1:0] MEM_RD,
    input  logic             MEM_RF_LE,
    input  logic [REG_W-1:0] WB_RD,
    input  logic             WB_RF_LE,
    input  logic             EX_BR_TAKEN,
    input  logic             EX_NULLIFY,
    input  logic             CNT_CLR,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             IF_ID_CLR,
    output logic             S,
    output logic [1:0]       FW_A,
    output logic [1:0]       FW_B,
    output logic [CNT_W-1:0] BUBBLE_CNT
);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [1:0]       fw_a_raw;
    logic [1:0]       fw_b_raw;
    logic             luh;
    logic [CNT_W-1:0] cnt;

    hazard_forward_unit_fwd_select #(.REG_W(REG_W)) u_fwd_a (
        .src       (ID_RA),
        .use_src   (ID_USE_A),
        .ex_rd     (EX_RD),
        .ex_rf_le  (EX_RF_LE),
        .mem_rd    (MEM_RD),
        .mem_rf_le (MEM_RF_LE),
        .wb_rd     (WB_RD),
        .wb_rf_le  (WB_RF_LE),
        .sel       (fw_a_raw)
    );

    hazard_forward_unit_fwd_select #(.REG_W(REG_W)) u_fwd_b (
        .src       (ID_RB),
        .use_src   (ID_USE_B),
        .ex_rd     (EX_RD),
        .ex_rf_le  (EX_RF_LE),
        .mem_rd    (MEM_RD),
        .mem_rf_le (MEM_RF_LE),
        .wb_rd     (WB_RD),
        .wb_rf_le  (WB_RF_LE),
        .sel       (fw_b_raw)
    );

    // Load in EX whose destination (non-r0) is read by the ID instruction
    always_comb begin
        luh = EX_L && EX_RF_LE && (EX_RD != REG_W'(REG_ZERO)) &&
              ((ID_USE_A && (ID_RA == EX_RD)) || (ID_USE_B && (ID_RB == EX_RD)));
    end

    // Pipeline control outputs and next-state; branch beats load-use
    always_comb begin
        PC_LE      = 1'b1;
        IF_ID_LE   = 1'b1;
        IF_ID_CLR  = 1'b0;
        S          = 1'b1;
        FW_A       = fw_a_raw;
        FW_B       = fw_b_raw;
        state_next = state;
        if (reset) begin
            FW_A       = FW_RF;
            FW_B       = FW_RF;
            state_next = ST_RUN;
        end else if (!LE) begin
            PC_LE      = 1'b0;
            IF_ID_LE   = 1'b0;
            state_next = state;
        end else begin
            case (state)
                ST_RUN: begin
                    if (EX_BR_TAKEN) begin
                        IF_ID_CLR  = 1'b1;
                        S          = EX_NULLIFY;
                        state_next = ST_FLUSH;
                    end else if (luh) begin
                        PC_LE      = 1'b0;
                        IF_ID_LE   = 1'b0;
                        state_next = ST_LU_STALL;
                    end else begin
                        S          = EX_NULLIFY;
                        state_next = ST_RUN;
                    end
                end
                ST_LU_STALL: begin
                    S          = 1'b0;
                    state_next = ST_RUN;
                end
                ST_FLUSH: begin
                    state_next = ST_RUN;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    // State and bubble counter; pipe freeze holds both, clear beats increment
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            if (LE) begin
                state <= state_next;
            end else begin
                state <= state;
            end
            if (CNT_CLR) begin
                cnt <= '0;
            end else if (LE && S && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= cnt;
            end
        end
    end

    assign BUBBLE_CNT = cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Randomized + directed bench for hazard_forward_unit against a behavioural model.
module tb_hazard_forward_unit;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int M_RUN = 0;
    localparam int M_STALL = 1;
    localparam int M_FLUSH = 2;

    logic clk = 1'b0;
    logic reset, LE, ID_USE_A, ID_USE_B, EX_RF_LE, EX_L, MEM_RF_LE, WB_RF_LE;
    logic EX_BR_TAKEN, EX_NULLIFY, CNT_CLR;
    logic [REG_W-1:0] ID_RA, ID_RB, EX_RD, MEM_RD, WB_RD;
    logic PC_LE, IF_ID_LE, IF_ID_CLR, S;
    logic [1:0] FW_A, FW_B;
    logic [CNT_W-1:0] BUBBLE_CNT;

    int n_pass = 0;
    int n_total = 0;
    int m_state = M_RUN;
    int m_cnt = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .LE(LE),
        .ID_RA(ID_RA), .ID_RB(ID_RB), .ID_USE_A(ID_USE_A), .ID_USE_B(ID_USE_B),
        .EX_RD(EX_RD), .EX_RF_LE(EX_RF_LE), .EX_L(EX_L),
        .MEM_RD(MEM_RD), .MEM_RF_LE(MEM_RF_LE), .WB_RD(WB_RD), .WB_RF_LE(WB_RF_LE),
        .EX_BR_TAKEN(EX_BR_TAKEN), .EX_NULLIFY(EX_NULLIFY), .CNT_CLR(CNT_CLR),
        .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .IF_ID_CLR(IF_ID_CLR), .S(S),
        .FW_A(FW_A), .FW_B(FW_B), .BUBBLE_CNT(BUBBLE_CNT)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference forwarding: scan producers youngest first
    function automatic int ref_fw(input int src, input bit use_it);
        int rd[3];
        bit wr[3];
        rd[0] = int'(EX_RD);  wr[0] = EX_RF_LE;
        rd[1] = int'(MEM_RD); wr[1] = MEM_RF_LE;
        rd[2] = int'(WB_RD);  wr[2] = WB_RF_LE;
        if (!use_it || src == 0) return 0;
        for (int k = 0; k < 3; k++) if (wr[k] && rd[k] == src) return k + 1;
        return 0;
    endfunction

    task automatic set_idle();
        reset = 0; LE = 1; CNT_CLR = 0;
        ID_RA = 0; ID_RB = 0; ID_USE_A = 0; ID_USE_B = 0;
        EX_RD = 0; EX_RF_LE = 0; EX_L = 0; MEM_RD = 0; MEM_RF_LE = 0;
        WB_RD = 0; WB_RF_LE = 0; EX_BR_TAKEN = 0; EX_NULLIFY = 0;
    endtask

    // Check one cycle mid-period, then advance the model across the edge
    task automatic step();
        bit e_pc, e_ifid, e_clr, e_s, hazard;
        int e_fa, e_fb, nxt;
        #4;
        e_fa = ref_fw(int'(ID_RA), ID_USE_A);
        e_fb = ref_fw(int'(ID_RB), ID_USE_B);
        hazard = EX_L && EX_RF_LE && EX_RD != 0 &&
                 ((ID_USE_A && ID_RA == EX_RD) || (ID_USE_B && ID_RB == EX_RD));
        e_pc = 1; e_ifid = 1; e_clr = 0; e_s = 1; nxt = m_state;
        if (reset) begin
            e_fa = 0; e_fb = 0;
        end else if (!LE) begin
            e_pc = 0; e_ifid = 0;
        end else if (m_state == M_STALL) begin
            e_s = 0; nxt = M_RUN;
        end else if (m_state == M_FLUSH) begin
            nxt = M_RUN;
        end else if (EX_BR_TAKEN) begin
            e_clr = 1; e_s = EX_NULLIFY; nxt = M_FLUSH;
        end else if (hazard) begin
            e_pc = 0; e_ifid = 0; nxt = M_STALL;
        end else begin
            e_s = EX_NULLIFY;
        end
        check("pc_le", 32'(PC_LE), 32'(e_pc));
        check("if_id_le", 32'(IF_ID_LE), 32'(e_ifid));
        check("if_id_clr", 32'(IF_ID_CLR), 32'(e_clr));
        check("s", 32'(S), 32'(e_s));
        check("fw_a", 32'(FW_A), 32'(e_fa));
        check("fw_b", 32'(FW_B), 32'(e_fb));
        check("bubble_cnt", 32'(BUBBLE_CNT), 32'(m_cnt));
        @(posedge clk);
        if (reset) begin
            m_state = M_RUN; m_cnt = 0;
        end else begin
            if (LE) m_state = nxt;
            if (CNT_CLR) m_cnt = 0;
            else if (LE && e_s && m_cnt < CNT_MAX) m_cnt++;
        end
        #1;
    endtask

    initial begin
        set_idle();
        reset = 1;
        @(posedge clk); #1;
        step();                                   // reset-cycle outputs
        set_idle(); step();

        // EX r3 (ALU) -> A, MEM r4 -> B
        ID_RA = 3; ID_RB = 4; ID_USE_A = 1; ID_USE_B = 1;
        EX_RD = 3; EX_RF_LE = 1; MEM_RD = 4; MEM_RF_LE = 1;
        step();
        check("dir_fw_ex_mem", {30'd0, FW_A}, 32'd1);

        // load r5 used as B: one bubble, then MEM forward
        set_idle(); ID_RB = 5; ID_USE_B = 1; EX_RD = 5; EX_RF_LE = 1; EX_L = 1;
        step();
        EX_RD = 0; EX_RF_LE = 0; EX_L = 0; MEM_RD = 5; MEM_RF_LE = 1;
        step();
        set_idle(); step();
        check("dir_lu_cnt", 32'(BUBBLE_CNT), 32'd1);

        // r0 load never forwards or stalls
        ID_RA = 0; ID_USE_A = 1; EX_RD = 0; EX_RF_LE = 1; EX_L = 1;
        step();

        // taken branch without nullify, then FLUSH bubble
        set_idle(); CNT_CLR = 1; step();
        set_idle(); EX_BR_TAKEN = 1; step();
        set_idle(); step(); step();
        check("dir_br_cnt", 32'(BUBBLE_CNT), 32'd1);

        // taken branch with nullify, reset during FLUSH
        EX_BR_TAKEN = 1; EX_NULLIFY = 1; step();
        set_idle(); reset = 1; step();
        set_idle(); step();
        check("dir_rst_cnt", 32'(BUBBLE_CNT), 32'd0);

        // freeze during LU_STALL for three cycles
        ID_RA = 7; ID_USE_A = 1; EX_RD = 7; EX_RF_LE = 1; EX_L = 1;
        step();
        EX_RD = 0; EX_RF_LE = 0; EX_L = 0; MEM_RD = 7; MEM_RF_LE = 1;
        LE = 0; step(); step(); step();
        LE = 1; step();
        set_idle(); step();

        // saturation then clear beating increment
        EX_NULLIFY = 1;
        for (int i = 0; i < CNT_MAX + 4; i++) step();
        check("dir_sat", 32'(BUBBLE_CNT), 32'(CNT_MAX));
        CNT_CLR = 1; step();
        CNT_CLR = 0; step();

        // randomized traffic over a small register range to force matches
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 49) == 0);
            LE          = ($urandom_range(0, 9) != 0);
            CNT_CLR     = ($urandom_range(0, 19) == 0) && LE;
            ID_RA       = REG_W'($urandom_range(0, 3));
            ID_RB       = REG_W'($urandom_range(0, 3));
            ID_USE_A    = 1'($urandom);
            ID_USE_B    = 1'($urandom);
            EX_RD       = REG_W'($urandom_range(0, 3));
            EX_RF_LE    = 1'($urandom);
            EX_L        = ($urandom_range(0, 2) == 0);
            MEM_RD      = REG_W'($urandom_range(0, 3));
            MEM_RF_LE   = 1'($urandom);
            WB_RD       = REG_W'($urandom_range(0, 3));
            WB_RF_LE    = 1'($urandom);
            EX_BR_TAKEN = ($urandom_range(0, 7) == 0);
            EX_NULLIFY  = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
